seg_execute_muldiv: RTL and testbench
=====================================

Name: seg_execute_muldiv

Overview:
Next-generation MIPS EX stage. Adds operand forwarding, HI/LO registers and an iterative multiply/divide unit that stalls the pipeline while it works. Sits between the ID/EX and EX/MEM latches, and owns the EX/MEM latch. Drives o_stall back to the hazard unit, which freezes IF/ID/EX.

Parameters:
LEN, 32, datapath width
NB_ADDR, 5, register index width
NB_FUNC, 6, funct field width
NB_CTRL_WB, 2, WB control bus width
NB_CTRL_M, 9, MEM control bus width
NB_CTRL_EX, 4, EX control bus: [0] RegDst, [1] ALUSrc, [3:2] ALUOp
NB_CNT, 6, iteration counter width (must hold LEN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_valid  in  1  ID/EX holds a real instruction
i_flush  in  1  synchronous kill of the EX instruction / muldiv op
i_PC  in  LEN  PC+4 of the instruction
i_read_data_1  in  LEN  rs value
i_read_data_2  in  LEN  rt value
i_addr_ext  in  LEN  sign-extended imm; [10:6]=shamt, [5:0]=funct
i_rt  in  NB_ADDR  instruction[20:16]
i_rd  in  NB_ADDR  instruction[15:11]
i_fwd_a, i_fwd_b  in  2  operand select: 00 reg, 01 EX/MEM, 10 MEM/WB
i_fwd_mem_data  in  LEN  EX/MEM forwarded value
i_fwd_wb_data  in  LEN  MEM/WB forwarded value
i_ctrl_wb_bus  in  NB_CTRL_WB
i_ctrl_mem_bus  in  NB_CTRL_M
i_ctrl_exc_bus  in  NB_CTRL_EX
o_stall  out  1  combinational, muldiv busy
o_valid  out  1  EX/MEM holds a real instruction
o_PC_branch  out  LEN  registered i_PC + (i_addr_ext<<2)
o_ALU_result  out  LEN  registered
o_write_data  out  LEN  registered forwarded operand B (pre-ALUSrc)
o_write_register  out  NB_ADDR  registered, RegDst ? rd : rt
o_ALU_zero  out  1  registered, ALU result == 0
o_ctrl_wb_bus  out  NB_CTRL_WB  registered
o_ctrl_mem_bus  out  NB_CTRL_M  registered

Behaviour:
- Reset (i_rst=0, async): all outputs 0, HI=LO=0, FSM=IDLE, counter=0.
- Operand A = fwd mux(rs); B_fwd = fwd mux(rt). Selector code 11 behaves as 00.
- Operand B = ALUSrc ? i_addr_ext : B_fwd.
- ALUOp 00: add. ALUOp 01: sub. ALUOp 11: OR with zero-extended imm[15:0].
- ALUOp 10: decode funct.
  - add/addu/sub/subu/and/or/xor/nor/slt/sltu: 100000–100111, 101010, 101011.
  - sll 000000, srl 000010, sra 000011: shift B by shamt.
  - mfhi 010000 / mflo 010010: result = HI / LO.
  - mthi 010001 / mtlo 010011: write A into HI / LO at the capture edge.
  - Unknown funct: result 0.
- Overflow is not trapped; results wrap modulo 2^LEN.
- Muldiv ops, ALUOp 10: mult 011000, multu 011001, div 011010, divu 011011.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE & i_valid & muldiv & !i_flush: latch operands (magnitudes and result sign for signed ops), go to MUL or DIV, counter=LEN.
  - MUL: shift-add, one bit per cycle. DIV: restoring divide, one bit per cycle. Counter decrements each cycle; when it reaches 1, go to DONE.
  - DONE: sign fix applied, HI/LO written, go to IDLE.
  - Multiply writes {HI,LO} = 2LEN-bit product. Divide writes LO = quotient, HI = remainder; the remainder takes the dividend's sign.
- o_stall = (IDLE & i_valid & muldiv & divisor≠0) | MUL | DIV. This gives exactly LEN+1 stall cycles.
- While stalled, the EX/MEM capture is a bubble: o_valid=0, ctrl buses 0. The data outputs may update.
- In DONE, stall is low and the muldiv instruction retires into EX/MEM with its ctrl buses and o_valid=1.
- Divide by zero: no stall, retires next edge; LO = all ones, HI = dividend.
- i_flush: EX/MEM captures a bubble. The FSM aborts to IDLE from any state; HI/LO are unchanged. A pending mthi/mtlo is not performed.
- mfhi in the cycle after DONE sees the new HI (HI/LO are written at the DONE edge).
- Non-muldiv capture: EX/MEM latch loads every edge with o_valid = i_valid & !i_flush. Latency is 1 cycle.

Optional Feature:
EXEC_FWD_EN
- Defined: i_fwd_a/i_fwd_b muxes are active as described above.
- Undefined: forwarding muxes are removed; operands come from i_read_data_1/2 directly, and the i_fwd_* inputs are ignored (left unconnected internally).

Test Plan:
- ALUOp 10, funct 100010, rs=5, rt=7 → next edge o_ALU_result=0xFFFFFFFE, o_ALU_zero=0, o_write_register=rd with RegDst=1.
- i_fwd_a=01, i_fwd_mem_data=0x10, rs=0x99, add, rt=1 → o_ALU_result=0x11. Without EXEC_FWD_EN the result is 0x9A.
- mult, rs=0xFFFFFFFE (−2), rt=3 → o_stall high 33 cycles, bubbles in EX/MEM. Then mfhi/mflo give 0xFFFFFFFF / 0xFFFFFFFA.
- divu, rs=100, rt=7 → after 33 stall cycles LO=14, HI=2. div, rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, rt=0, rs=0x1234 → o_stall never asserts; LO=0xFFFFFFFF, HI=0x1234.
- Abort cases:
  - i_flush at cycle 10 of a mult → o_stall drops next cycle; HI/LO retain their prior values (e.g. 0).
  - i_rst pulsed low mid-divide → all outputs, HI and LO read 0 immediately, FSM=IDLE.

Source files
------------

// File: rtl/seg_execute_muldiv.sv
// MIPS EX stage: operand forwarding, ALU, HI/LO and an iterative multiply/divide unit that stalls the pipeline.
// Optional feature macro: EXEC_FWD_EN (enables the i_fwd_a/i_fwd_b forwarding muxes).
module seg_execute_muldiv #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_FUNC    = 6,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 9,
  parameter int NB_CTRL_EX = 4,
  parameter int NB_CNT     = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [LEN-1:0]        i_PC,
  input  logic [LEN-1:0]        i_read_data_1,
  input  logic [LEN-1:0]        i_read_data_2,
  input  logic [LEN-1:0]        i_addr_ext,
  input  logic [NB_ADDR-1:0]    i_rt,
  input  logic [NB_ADDR-1:0]    i_rd,
  input  logic [1:0]            i_fwd_a,
  input  logic [1:0]            i_fwd_b,
  input  logic [LEN-1:0]        i_fwd_mem_data,
  input  logic [LEN-1:0]        i_fwd_wb_data,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [LEN-1:0]        o_PC_branch,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [LEN-1:0]        o_write_data,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic                  o_ALU_zero,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                state_reg, state_next;
  logic [NB_CNT-1:0]     cnt_reg;
  logic [2*LEN-1:0]      work_reg;
  logic [LEN-1:0]        mcand_reg;
  logic                  op_div_reg, neg_q_reg, neg_r_reg;
  logic [LEN-1:0]        hi_reg, lo_reg;

  logic                  reg_dst, alu_src;
  logic [1:0]            alu_op;
  logic [NB_FUNC-1:0]    funct;
  logic [4:0]            shamt;
  logic [LEN-1:0]        op_a, b_fwd, op_b, alu_res;

  assign reg_dst = i_ctrl_exc_bus[0];
  assign alu_src = i_ctrl_exc_bus[1];
  assign alu_op  = i_ctrl_exc_bus[3:2];
  assign funct   = i_addr_ext[NB_FUNC-1:0];
  assign shamt   = i_addr_ext[10:6];

`ifdef EXEC_FWD_EN
  logic [LEN-1:0] reg_val [2];
  logic [1:0]     fwd_sel [2];
  logic [LEN-1:0] fwd_val [2];
  assign reg_val[0] = i_read_data_1;
  assign reg_val[1] = i_read_data_2;
  assign fwd_sel[0] = i_fwd_a;
  assign fwd_sel[1] = i_fwd_b;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Code 11 falls through to the register value.
      assign fwd_val[gi] = (fwd_sel[gi] == 2'b01) ? i_fwd_mem_data :
                           (fwd_sel[gi] == 2'b10) ? i_fwd_wb_data  : reg_val[gi];
    end
  endgenerate
  assign op_a  = fwd_val[0];
  assign b_fwd = fwd_val[1];
`else
  logic unused_fwd;
  assign unused_fwd = ^{i_fwd_a, i_fwd_b, i_fwd_mem_data, i_fwd_wb_data};
  assign op_a  = i_read_data_1;
  assign b_fwd = i_read_data_2;
`endif

  assign op_b = alu_src ? i_addr_ext : b_fwd;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | {{(LEN-16){1'b0}}, i_addr_ext[15:0]};
      default: begin
        case (funct)
          6'b100000, 6'b100001: alu_res = op_a + op_b;
          6'b100010, 6'b100011: alu_res = op_a - op_b;
          6'b100100: alu_res = op_a & op_b;
          6'b100101: alu_res = op_a | op_b;
          6'b100110: alu_res = op_a ^ op_b;
          6'b100111: alu_res = ~(op_a | op_b);
          6'b101010: alu_res = {{(LEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          6'b101011: alu_res = {{(LEN-1){1'b0}}, op_a < op_b};
          6'b000000: alu_res = op_b << shamt;
          6'b000010: alu_res = op_b >> shamt;
          6'b000011: alu_res = $unsigned($signed(op_b) >>> shamt);
          6'b010000: alu_res = hi_reg;
          6'b010010: alu_res = lo_reg;
          default:   alu_res = '0;
        endcase
      end
    endcase
  end

  // Muldiv decode: operands are rs (A) and rt (B, before the immediate mux).
  logic           is_muldiv, is_div, is_signed, div_zero, start, a_neg, b_neg;
  logic [LEN-1:0] a_mag, b_mag;
  assign is_muldiv = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);
  assign is_div    = funct[1];
  assign is_signed = !funct[0];
  assign div_zero  = is_div && (b_fwd == '0);
  assign start     = (state_reg == IDLE) && i_valid && is_muldiv && !i_flush;
  assign a_neg     = is_signed && op_a[LEN-1];
  assign b_neg     = is_signed && b_fwd[LEN-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -b_fwd : b_fwd;

  // Shift-add multiply: work_reg = {partial product, remaining multiplier bits}.
  logic [LEN:0]     mul_sum;
  logic [2*LEN-1:0] mul_next;
  assign mul_sum  = {1'b0, work_reg[2*LEN-1:LEN]} + (work_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_next = {mul_sum, work_reg[LEN-1:1]};

  // Restoring divide: work_reg = {remainder, dividend/quotient}.
  logic [LEN:0]     div_shift, div_trial;
  logic [2*LEN-1:0] div_next;
  assign div_shift = {work_reg[2*LEN-1:LEN], work_reg[LEN-1]};
  assign div_trial = div_shift - {1'b0, mcand_reg};
  assign div_next  = div_trial[LEN] ? {div_shift[LEN-1:0], work_reg[LEN-2:0], 1'b0}
                                    : {div_trial[LEN-1:0], work_reg[LEN-2:0], 1'b1};

  logic [2*LEN-1:0] prod_fix;
  logic [LEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q_reg ? -work_reg : work_reg;
  assign quo_fix  = neg_q_reg ? -work_reg[LEN-1:0] : work_reg[LEN-1:0];
  assign rem_fix  = neg_r_reg ? -work_reg[2*LEN-1:LEN] : work_reg[2*LEN-1:LEN];

  always_comb begin
    state_next = state_reg;
    o_stall    = (start && !div_zero) || (state_reg == MUL) || (state_reg == DIV);
    case (state_reg)
      IDLE:     if (start && !div_zero) state_next = is_div ? DIV : MUL;
      MUL, DIV: if (cnt_reg == NB_CNT'(1)) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      work_reg         <= '0;
      mcand_reg        <= '0;
      op_div_reg       <= 1'b0;
      neg_q_reg        <= 1'b0;
      neg_r_reg        <= 1'b0;
      hi_reg           <= '0;
      lo_reg           <= '0;
      o_valid          <= 1'b0;
      o_PC_branch      <= '0;
      o_ALU_result     <= '0;
      o_write_data     <= '0;
      o_write_register <= '0;
      o_ALU_zero       <= 1'b0;
      o_ctrl_wb_bus    <= '0;
      o_ctrl_mem_bus   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          cnt_reg    <= NB_CNT'(LEN);
          work_reg   <= {{LEN{1'b0}}, (is_div ? a_mag : b_mag)};
          mcand_reg  <= is_div ? b_mag : a_mag;
          op_div_reg <= is_div;
          neg_q_reg  <= a_neg ^ b_neg;
          neg_r_reg  <= a_neg;
        end
        MUL: begin
          work_reg <= mul_next;
          cnt_reg  <= cnt_reg - NB_CNT'(1);
        end
        DIV: begin
          work_reg <= div_next;
          cnt_reg  <= cnt_reg - NB_CNT'(1);
        end
        default: ;
      endcase

      if (state_reg == DONE && !i_flush) begin
        if (op_div_reg) begin
          lo_reg <= quo_fix;
          hi_reg <= rem_fix;
        end else begin
          {hi_reg, lo_reg} <= prod_fix;
        end
      end else if (start && div_zero) begin
        hi_reg <= op_a;
        lo_reg <= '1;
      end else if (i_valid && !i_flush && state_reg == IDLE && alu_op == 2'b10) begin
        if (funct == 6'b010001) hi_reg <= op_a;
        if (funct == 6'b010011) lo_reg <= op_a;
      end

      o_valid          <= i_valid && !i_flush && !o_stall;
      o_ctrl_wb_bus    <= (i_flush || o_stall) ? '0 : i_ctrl_wb_bus;
      o_ctrl_mem_bus   <= (i_flush || o_stall) ? '0 : i_ctrl_mem_bus;
      o_PC_branch      <= i_PC + (i_addr_ext << 2);
      o_ALU_result     <= alu_res;
      o_write_data     <= b_fwd;
      o_write_register <= reg_dst ? i_rd : i_rt;
      o_ALU_zero       <= (alu_res == '0);
    end
  end

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// Scoreboard bench for seg_execute_muldiv: ALU, forwarding, mul/div stalls, flush and reset aborts.
module tb_seg_execute_muldiv;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush;
  logic [31:0] i_PC, i_read_data_1, i_read_data_2, i_addr_ext, i_fwd_mem_data, i_fwd_wb_data;
  logic [4:0]  i_rt, i_rd;
  logic [1:0]  i_fwd_a, i_fwd_b, i_ctrl_wb_bus;
  logic [8:0]  i_ctrl_mem_bus;
  logic [3:0]  i_ctrl_exc_bus;
  logic        o_stall, o_valid, o_ALU_zero;
  logic [31:0] o_PC_branch, o_ALU_result, o_write_data;
  logic [4:0]  o_write_register;
  logic [1:0]  o_ctrl_wb_bus;
  logic [8:0]  o_ctrl_mem_bus;

  seg_execute_muldiv dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush), .i_PC(i_PC),
    .i_read_data_1(i_read_data_1), .i_read_data_2(i_read_data_2), .i_addr_ext(i_addr_ext),
    .i_rt(i_rt), .i_rd(i_rd), .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
    .i_fwd_mem_data(i_fwd_mem_data), .i_fwd_wb_data(i_fwd_wb_data),
    .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus), .i_ctrl_exc_bus(i_ctrl_exc_bus),
    .o_stall(o_stall), .o_valid(o_valid), .o_PC_branch(o_PC_branch), .o_ALU_result(o_ALU_result),
    .o_write_data(o_write_data), .o_write_register(o_write_register), .o_ALU_zero(o_ALU_zero),
    .o_ctrl_wb_bus(o_ctrl_wb_bus), .o_ctrl_mem_bus(o_ctrl_mem_bus)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [1:0] WB_C  = 2'b10;
  localparam logic [8:0] MEM_C = 9'h1A5;

  typedef struct {logic [31:0] res; logic [31:0] wdata; logic [31:0] pcb; logic [4:0] wreg; logic zero;} exp_t;
  typedef struct {logic [1:0] op; logic src; logic dst; logic [31:0] a; logic [31:0] b; logic [31:0] ext; logic [31:0] res;} alu_vec_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic dst,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext);
    i_valid = 1'b1; i_flush = 1'b0; i_fwd_a = 2'b00; i_fwd_b = 2'b00;
    i_read_data_1 = a; i_read_data_2 = b; i_addr_ext = ext;
    i_ctrl_exc_bus = {op, src, dst};
    i_PC = i_PC + 32'd4;
  endtask

  task automatic test_reset();
    exp_t e;
    i_rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'h1234, 32'h5678, 32'h9);
    repeat (3) tick();
    total++;
    if ({o_valid, o_ALU_zero, o_stall} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got valid=%b zero=%b stall=%b want 000", o_valid, o_ALU_zero, o_stall);
    end
    total++;
    if ({o_PC_branch, o_ALU_result, o_write_data} !== 96'd0) begin
      bad++; $display("FAIL reset_data got pcb=%h res=%h wd=%h want 0", o_PC_branch, o_ALU_result, o_write_data);
    end
    total++;
    if ({o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus} !== 16'd0) begin
      bad++; $display("FAIL reset_ctrl got wr=%0d wb=%h mem=%h want 0", o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus);
    end
    i_rst = 1'b1;
    drive(2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10);
    exp_q.push_back('{32'h0, 32'h0, 32'h0, 5'd9, 1'b1});
    tick();
    total++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL reset_mfhi_valid got=%b want=1", o_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (o_ALU_result !== e.res) begin bad++; $display("FAIL reset_mfhi got=%h want=%h", o_ALU_result, e.res); end
    end
    $display("txn reset mfhi res=%h", o_ALU_result);
  endtask

  task automatic test_alu();
    alu_vec_t tab[14];
    exp_t     e;
    tab = '{
      '{2'b10, 1'b0, 1'b1, 32'd5,        32'd7,        32'h22,       32'hFFFFFFFE},
      '{2'b10, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1,        32'h20,       32'h80000000},
      '{2'b10, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h24,       32'hF000F000},
      '{2'b10, 1'b0, 1'b1, 32'h0000FFFF, 32'h00FF0000, 32'h27,       32'hFF000000},
      '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h2A,       32'd1},
      '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'h2B,       32'd0},
      '{2'b10, 1'b0, 1'b1, 32'h3,        32'hF,        32'h100,      32'hF0},
      '{2'b10, 1'b0, 1'b1, 32'h3,        32'h80000000, 32'h103,      32'hF8000000},
      '{2'b10, 1'b0, 1'b1, 32'h3,        32'h80000000, 32'h102,      32'h08000000},
      '{2'b10, 1'b0, 1'b1, 32'hAAAA5555, 32'hFFFF0000, 32'h26,       32'h55555555},
      '{2'b00, 1'b1, 1'b0, 32'h1000,     32'h77,       32'hFFFFFFFC, 32'h00000FFC},
      '{2'b01, 1'b0, 1'b0, 32'h1234,     32'h1234,     32'h0,        32'h0},
      '{2'b11, 1'b1, 1'b0, 32'h12340000, 32'h5,        32'hFFFF8001, 32'h12348001},
      '{2'b10, 1'b0, 1'b1, 32'h55,       32'h66,       32'h3F,       32'h0}
    };
    for (int i = 0; i < 14; i++) begin
      drive(tab[i].op, tab[i].src, tab[i].dst, tab[i].a, tab[i].b, tab[i].ext);
      exp_q.push_back('{tab[i].res, tab[i].b, i_PC + (tab[i].ext << 2), (tab[i].dst ? 5'd9 : 5'd3), (tab[i].res == 32'd0)});
      tick();
      total++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL alu_valid[%0d] got=%b want=1", i, o_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if ({o_ALU_result, o_write_data, o_PC_branch, o_write_register, o_ALU_zero} !== {e.res, e.wdata, e.pcb, e.wreg, e.zero}) begin
          bad++;
          $display("FAIL alu[%0d] got res=%h wd=%h pcb=%h wr=%0d z=%b want res=%h wd=%h pcb=%h wr=%0d z=%b",
                   i, o_ALU_result, o_write_data, o_PC_branch, o_write_register, o_ALU_zero,
                   e.res, e.wdata, e.pcb, e.wreg, e.zero);
        end
        total++;
        if (o_ctrl_wb_bus !== WB_C || o_ctrl_mem_bus !== MEM_C) begin
          bad++; $display("FAIL alu_ctrl[%0d] got wb=%h mem=%h want wb=%h mem=%h", i, o_ctrl_wb_bus, o_ctrl_mem_bus, WB_C, MEM_C);
        end
      end
      $display("txn alu[%0d] res=%h", i, o_ALU_result);
    end
  endtask

  task automatic test_fwd();
    logic [1:0]  fa[3], fb[3];
    logic [31:0] a[3], b[3], mem[3], wb[3], res[3], wd[3];
    exp_t        e;
    fa = '{2'b01, 2'b00, 2'b11}; fb = '{2'b00, 2'b10, 2'b11};
    a = '{32'h99, 32'h1, 32'h4}; b = '{32'h1, 32'h55, 32'h1};
    mem = '{32'h10, 32'hBAD0, 32'h1000}; wb = '{32'hDEAD, 32'h20, 32'h2000};
`ifdef EXEC_FWD_EN
    res = '{32'h11, 32'h21, 32'h5}; wd = '{32'h1, 32'h20, 32'h1};
`else
    res = '{32'h9A, 32'h56, 32'h5}; wd = '{32'h1, 32'h55, 32'h1};
`endif
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b0, 1'b1, a[i], b[i], 32'h20);
      i_fwd_a = fa[i]; i_fwd_b = fb[i]; i_fwd_mem_data = mem[i]; i_fwd_wb_data = wb[i];
      exp_q.push_back('{res[i], wd[i], i_PC + 32'h80, 5'd9, 1'b0});
      tick();
      total++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL fwd_valid[%0d] got=%b want=1", i, o_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (o_ALU_result !== e.res || o_write_data !== e.wdata) begin
          bad++; $display("FAIL fwd[%0d] got res=%h wd=%h want res=%h wd=%h", i, o_ALU_result, o_write_data, e.res, e.wdata);
        end
      end
      $display("txn fwd[%0d] res=%h", i, o_ALU_result);
    end
    i_fwd_a = 2'b00; i_fwd_b = 2'b00;
  endtask

  task automatic test_muldiv(input string name, input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] q, r;
    longint      sa, sb;
    int          n, bubble_err, want_stall;
    exp_t        e;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    if (!funct[1]) begin
      prod = funct[0] ? ({32'd0, a} * {32'd0, b}) : 64'(sa * sb);
      q = prod[31:0]; r = prod[63:32];
    end else if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a;
    end else if (!funct[0]) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    want_stall = (funct[1] && b == 32'd0) ? 0 : 33;
    drive(2'b10, 1'b0, 1'b1, a, b, {26'd0, funct});
    n = 0; bubble_err = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (o_stall !== 1'b1) break;
      n++;
      tick();
      if (o_valid !== 1'b0 || o_ctrl_wb_bus !== 2'b00 || o_ctrl_mem_bus !== 9'd0) bubble_err++;
    end
    total++;
    if (n != want_stall) begin bad++; $display("FAIL %s_stall_cycles got=%0d want=%0d", name, n, want_stall); end
    total++;
    if (bubble_err != 0) begin bad++; $display("FAIL %s_bubbles got=%0d non-bubble captures want=0", name, bubble_err); end
    tick();
    total++;
    if (o_valid !== 1'b1 || o_write_register !== 5'd9 || o_ctrl_wb_bus !== WB_C) begin
      bad++; $display("FAIL %s_retire got valid=%b wr=%0d wb=%h want 1/9/%h", name, o_valid, o_write_register, o_ctrl_wb_bus, WB_C);
    end
    model_hi = r; model_lo = q;
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b0, 1'b1, 32'h0, 32'h0, (k == 0) ? 32'h10 : 32'h12);
      exp_q.push_back('{(k == 0) ? model_hi : model_lo, 32'h0, 32'h0, 5'd9, 1'b0});
      tick();
      total++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL %s_read%0d_valid got=%b want=1", name, k, o_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (o_ALU_result !== e.res) begin
          bad++; $display("FAIL %s_%s got=%h want=%h", name, (k == 0) ? "hi" : "lo", o_ALU_result, e.res);
        end
      end
    end
    $display("txn %s a=%h b=%h stall=%0d hi=%h lo=%h", name, a, b, n, model_hi, model_lo);
  endtask

  task automatic test_flush();
    exp_t e;
    drive(2'b10, 1'b0, 1'b1, 32'hCAFE, 32'h0, 32'h11);
    tick();
    drive(2'b10, 1'b0, 1'b1, 32'hBEEF, 32'h0, 32'h13);
    tick();
    model_hi = 32'hCAFE; model_lo = 32'hBEEF;
    drive(2'b10, 1'b0, 1'b1, 32'h1111, 32'h0, 32'h11);
    i_flush = 1'b1;
    tick();
    total++;
    if (o_valid !== 1'b0 || o_ctrl_wb_bus !== 2'b00 || o_ctrl_mem_bus !== 9'd0) begin
      bad++; $display("FAIL flush_bubble got valid=%b wb=%h mem=%h want 0", o_valid, o_ctrl_wb_bus, o_ctrl_mem_bus);
    end
    drive(2'b10, 1'b0, 1'b1, 32'd7, 32'd9, 32'h18);
    repeat (9) tick();
    i_flush = 1'b1;
    #1;
    total++;
    if (o_stall !== 1'b1) begin bad++; $display("FAIL flush_busy got stall=%b want=1", o_stall); end
    tick();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_mult_bubble got valid=%b want=0", o_valid); end
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b0, 1'b1, 32'h0, 32'h0, (k == 0) ? 32'h10 : 32'h12);
      #1;
      total++;
      if (o_stall !== 1'b0) begin bad++; $display("FAIL flush_stall_drop[%0d] got=%b want=0", k, o_stall); end
      exp_q.push_back('{(k == 0) ? model_hi : model_lo, 32'h0, 32'h0, 5'd9, 1'b0});
      tick();
      total++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL flush_read%0d_valid got=%b want=1", k, o_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (o_ALU_result !== e.res) begin bad++; $display("FAIL flush_keep%0d got=%h want=%h", k, o_ALU_result, e.res); end
      end
      $display("txn flush read%0d res=%h", k, o_ALU_result);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    drive(2'b10, 1'b0, 1'b1, 32'd100, 32'd7, 32'h1B);
    repeat (5) tick();
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    total++;
    if ({o_valid, o_ALU_zero, o_stall} !== 3'b000) begin
      bad++; $display("FAIL rstmid_flags got valid=%b zero=%b stall=%b want 000", o_valid, o_ALU_zero, o_stall);
    end
    total++;
    if ({o_PC_branch, o_ALU_result, o_write_data, o_write_register, o_ctrl_wb_bus, o_ctrl_mem_bus} !== 112'd0) begin
      bad++; $display("FAIL rstmid_outputs got pcb=%h wd=%h wr=%0d want 0", o_PC_branch, o_write_data, o_write_register);
    end
    tick();
    i_rst = 1'b1;
    model_hi = '0; model_lo = '0;
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b0, 1'b1, 32'h0, 32'h0, (k == 0) ? 32'h10 : 32'h12);
      exp_q.push_back('{(k == 0) ? model_hi : model_lo, 32'h0, 32'h0, 5'd9, 1'b0});
      tick();
      total++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++; $display("FAIL rstmid_read%0d_valid got=%b want=1", k, o_valid);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (o_ALU_result !== e.res) begin bad++; $display("FAIL rstmid_hilo%0d got=%h want=%h", k, o_ALU_result, e.res); end
      end
      $display("txn rstmid read%0d res=%h", k, o_ALU_result);
    end
  endtask

  initial begin
    i_PC = 32'h0040_0000; i_rt = 5'd3; i_rd = 5'd9;
    i_ctrl_wb_bus = WB_C; i_ctrl_mem_bus = MEM_C;
    i_fwd_mem_data = '0; i_fwd_wb_data = '0;
    test_reset();
    test_alu();
    test_fwd();
    test_muldiv("mult", 6'h18, 32'hFFFFFFFE, 32'd3);
    test_muldiv("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    test_muldiv("divu", 6'h1B, 32'd100, 32'd7);
    test_muldiv("div", 6'h1A, 32'hFFFFFFF9, 32'd2);
    test_muldiv("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    test_muldiv("div0", 6'h1A, 32'h1234, 32'd0);
    test_flush();
    test_rst_mid();
    test_muldiv("divu_after_rst", 6'h1B, 32'd1000, 32'd33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
